// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: size encodings, head FSM states
// and the queued request record.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } dmem_state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        err;
    } dmem_req_t;

    // Size code 11 is illegal; half and word accesses must be naturally aligned.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == 2'b11) ||
               (size == SZ_HALF && addr_lo[0]) ||
               (size == SZ_WORD && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_req_fifo.sv
// In-order request queue between acceptance and the response FSM.
// Head entry is presented combinationally; payload storage is not reset.
module dmem_req_fifo
    import dmem_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  dmem_req_t                 entry_i,
    input  logic                      pop_i,
    output dmem_req_t                 head_o,
    output logic [$clog2(QDEPTH):0]   count_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;

    dmem_req_t         entries_q [QDEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PW'(QDEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PW'(QDEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            entries_q[wr_ptr_q] <= entry_i;
        end
    end

    assign head_o  = entries_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(QDEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/dmem_sram_responder.sv
// SRAM-like data-port responder: queues load/store requests in order, delays each
// by WAIT_CYCLES, then pulses data_ok with load data or an error flag.
module dmem_sram_responder
    import dmem_pkg::*;
#(
    parameter int WORDS       = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int QDEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int          AW      = $clog2(WORDS);
    localparam int          CW      = $clog2(QDEPTH) + 1;
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

    logic [3:0][7:0] mem_q [WORDS];

    dmem_state_e     state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    dmem_req_t       entry, head;
    logic [CW-1:0]   count;
    logic            full, empty, push, pop;
    logic [AW-1:0]   hidx;
    logic            unused_head;

    assign addr_ok = rst && !full;
    assign push    = req && addr_ok;
    assign pop     = (state_q == S_RESP);

    always_comb begin
        entry       = '0;
        entry.wr    = wr;
        entry.size  = size;
        entry.addr  = addr;
        entry.wstrb = wstrb;
        entry.wdata = wdata;
        entry.err   = req_bad(size, addr[1:0]);
    end

    dmem_req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .entry_i (entry),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // WAIT lasts WAIT_CYCLES cycles; the cycle before it (IDLE or RESP) adds one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (count > CW'(1)) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hidx = head.addr[AW+1:2];

    // Stores commit only on the response edge, so a reset beforehand drops them whole.
    always_ff @(posedge clk) begin
        if (rst && pop && head.wr && !head.err) begin
            for (int i = 0; i < 4; i++) begin
                if (head.wstrb[i]) begin
                    mem_q[hidx][i] <= head.wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_ok = pop;
    assign err     = pop && head.err;
    assign rdata   = (pop && !head.wr && !head.err) ? mem_q[hidx] : '0;
    assign busy    = !empty;

    assign unused_head = ^{head.size, head.addr[31:AW+2], head.addr[1:0]};

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Scoreboard bench for dmem_sram_responder: directed requests push expected
// responses; a negedge monitor pops and compares on every data_ok.
module tb_dmem_sram_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] wdata = '0;
    logic        addr_ok, data_ok, err, busy;
    logic [31:0] rdata;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc      = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    dmem_sram_responder #(.WORDS(1024), .WAIT_CYCLES(2), .QDEPTH(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata),
        .err     (err),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && data_ok) begin
            if (sb.size() == 0) begin
                chk("unexpected_data_ok", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_err", {31'd0, err}, {31'd0, e.err});
                chk("resp_rdata", rdata, e.rdata);
                chk("resp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [3:0] st, input logic [31:0] d,
                         input logic ee, input logic [31:0] er, input int lat,
                         output int stall);
        exp_t e;
        req = 1'b1; wr = w; size = sz; addr = a; wstrb = st; wdata = d;
        stall = 0;
        while (!addr_ok && stall < 50) begin
            @(posedge clk); #1;
            stall++;
        end
        if (!addr_ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge clk); #1;
        e.err = ee; e.rdata = er; e.acc = cyc; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        req = 1'b0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", {31'd0, n >= 100}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s;
        // reset held with a request pending
        req = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_addr_ok", {31'd0, addr_ok}, 32'd0);
        chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        req = 1'b0;
        rst = 1'b1;
        #1;
        chk("post_rst_addr_ok", {31'd0, addr_ok}, 32'd1);
        @(posedge clk); #1;

        issue(1'b1, SZ_WORD, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0, 3, s);
        drain();
        issue(1'b0, SZ_WORD, 32'h100, 4'b0000, 32'h0, 1'b0, 32'hDEADBEEF, 3, s);
        drain();

        issue(1'b1, SZ_WORD, 32'h100, 4'b1111, 32'h11223344, 1'b0, 32'h0, 3, s);
        drain();
        issue(1'b1, SZ_BYTE, 32'h101, 4'b0010, 32'h0000AB00, 1'b0, 32'h0, 3, s);
        drain();
        issue(1'b0, SZ_WORD, 32'h100, 4'b0000, 32'h0, 1'b0, 32'h1122AB44, 3, s);
        drain();

        // error entries: misaligned load/store, illegal size, odd half
        issue(1'b0, SZ_WORD, 32'h102, 4'b0000, 32'h0, 1'b1, 32'h0, 3, s);
        drain();
        issue(1'b1, SZ_WORD, 32'h102, 4'b1111, 32'hFFFFFFFF, 1'b1, 32'h0, 3, s);
        drain();
        issue(1'b1, 2'b11, 32'h100, 4'b1111, 32'hFFFFFFFF, 1'b1, 32'h0, 3, s);
        drain();
        issue(1'b1, SZ_HALF, 32'h101, 4'b0110, 32'h00FFFF00, 1'b1, 32'h0, 3, s);
        drain();
        issue(1'b0, SZ_WORD, 32'h100, 4'b0000, 32'h0, 1'b0, 32'h1122AB44, 3, s);
        drain();

        issue(1'b1, SZ_HALF, 32'h102, 4'b1100, 32'hCAFE0000, 1'b0, 32'h0, 3, s);
        issue(1'b0, SZ_WORD, 32'h100, 4'b0000, 32'h0, 1'b0, 32'hCAFEAB44, 5, s);
        drain();

        // three back-to-back requests against a two-entry queue
        issue(1'b1, SZ_WORD, 32'h10, 4'b1111, 32'hAAAA5555, 1'b0, 32'h0, 3, s);
        issue(1'b0, SZ_WORD, 32'h10, 4'b0000, 32'h0, 1'b0, 32'hAAAA5555, 5, s);
        chk("b2b_second_stall", s, 32'd0);
        issue(1'b0, SZ_WORD, 32'h100, 4'b0000, 32'h0, 1'b0, 32'hCAFEAB44, 4, s);
        chk("b2b_third_stall", s, 32'd3);
        drain();

        // reset one cycle after accepting a store: it must never commit or respond
        issue(1'b1, SZ_WORD, 32'h400, 4'b1111, 32'h55AA55AA, 1'b0, 32'h0, 3, s);
        drain();
        issue(1'b1, SZ_WORD, 32'h400, 4'b1111, 32'h12345678, 1'b0, 32'h0, 3, s);
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_data_ok", {31'd0, data_ok}, 32'd0);
        chk("midrst_addr_ok", {31'd0, addr_ok}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_busy_after", {31'd0, busy}, 32'd0);
        issue(1'b0, SZ_WORD, 32'h400, 4'b0000, 32'h0, 1'b0, 32'h55AA55AA, 3, s);
        drain();

        chk("sb_empty_end", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
